// File: rtl/chan_scan_pkg.sv
// Shared encodings for the channel scan multiplexer: mode input values and FSM states.
package chan_scan_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_SCAN   = 2'b01,
        MODE_HOLD   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_MANUAL = 2'b01,
        ST_SCAN   = 2'b10,
        ST_HOLD   = 2'b11
    } state_t;

    // Reserved mode is folded into HOLD.
    function automatic state_t mode_to_state(input mode_t m);
        case (m)
            MODE_MANUAL: return ST_MANUAL;
            MODE_SCAN:   return ST_SCAN;
            default:     return ST_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Counts 0..DWELL-1 while enabled; tc marks the last cycle of a dwell and the
// counter rolls back to 0 on the same edge.
module dwell_timer #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] count;

    assign tc = enable && (count == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || tc) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/chan_scan_mux.sv
// Registered N-way channel multiplexer with manual select, timed round-robin
// scan over enabled channels, and hold.
module chan_scan_mux
    import chan_scan_pkg::*;
#(
    parameter int W     = 4,
    parameter int N     = 4,
    parameter int DWELL = 4,
    localparam int SW   = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  din,
    input  logic [SW-1:0]   sel,
    input  logic [1:0]      mode,
    input  logic [N-1:0]    en_mask,
    output logic [W-1:0]    z,
    output logic [SW-1:0]   cur_ch,
    output logic            z_valid,
    output logic            wrap
);
    state_t        state, state_nxt;
    mode_t         mode_e;
    logic [W-1:0]  ch_data [N];
    logic [SW-1:0] nxt_ch, start_ch, cur_nxt;
    logic [W-1:0]  z_nxt;
    logic          valid_nxt, wrap_nxt;
    logic          scan_act, scan_act_nxt;
    logic          cur_en, mask_any, sel_ok, scan_run, t_clear, tc;

    assign mode_e = mode_t'(mode);

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign ch_data[i] = din[i*W +: W];
    end

    assign cur_en   = en_mask[cur_ch];
    assign mask_any = |en_mask;
    assign sel_ok   = 32'(sel) < N;
    assign start_ch = cur_en ? cur_ch : nxt_ch;

    // scan_act is set only after an edge that actually scanned, so the first
    // SCAN edge after any other mode (or the IDLE cycle) is treated as entry.
    assign scan_run = (state != ST_IDLE) && (mode_e == MODE_SCAN) && scan_act
                      && mask_any && cur_en;

    dwell_timer #(.DWELL(DWELL)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (t_clear),
        .enable (scan_run),
        .tc     (tc)
    );

    // Next enabled channel above cur_ch, wrapping; cur_ch itself is the last candidate.
    always_comb begin
        logic          found;
        logic [SW-1:0] idx;
        nxt_ch = cur_ch;
        found  = 1'b0;
        for (int i = 1; i <= N; i++) begin
            idx = SW'((int'(cur_ch) + i) % N);
            if (!found && en_mask[idx]) begin
                nxt_ch = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = mode_to_state(mode_e);
        z_nxt        = z;
        cur_nxt      = cur_ch;
        valid_nxt    = z_valid;
        wrap_nxt     = 1'b0;
        t_clear      = 1'b0;
        scan_act_nxt = 1'b0;
        if (state != ST_IDLE) begin
            case (mode_e)
                MODE_MANUAL: begin
                    if (sel_ok) begin
                        z_nxt     = ch_data[sel];
                        cur_nxt   = sel;
                        valid_nxt = 1'b1;
                    end else begin
                        z_nxt     = '0;
                        valid_nxt = 1'b0;
                    end
                end
                MODE_SCAN: begin
                    if (!mask_any) begin
                        z_nxt     = '0;
                        valid_nxt = 1'b0;
                        t_clear   = 1'b1;
                    end else if (!scan_act) begin
                        t_clear      = 1'b1;
                        cur_nxt      = start_ch;
                        z_nxt        = ch_data[start_ch];
                        valid_nxt    = 1'b1;
                        scan_act_nxt = 1'b1;
                    end else if (!cur_en || tc) begin
                        t_clear      = !cur_en;
                        cur_nxt      = nxt_ch;
                        z_nxt        = ch_data[nxt_ch];
                        valid_nxt    = 1'b1;
                        wrap_nxt     = (nxt_ch <= cur_ch);
                        scan_act_nxt = 1'b1;
                    end else begin
                        z_nxt        = ch_data[cur_ch];
                        valid_nxt    = 1'b1;
                        scan_act_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            z        <= '0;
            cur_ch   <= '0;
            z_valid  <= 1'b0;
            wrap     <= 1'b0;
            scan_act <= 1'b0;
        end else begin
            state    <= state_nxt;
            z        <= z_nxt;
            cur_ch   <= cur_nxt;
            z_valid  <= valid_nxt;
            wrap     <= wrap_nxt;
            scan_act <= scan_act_nxt;
        end
    end

endmodule

// File: tb/tb_chan_scan_mux.sv
// Directed bench for chan_scan_mux: a per-cycle vector table plus hand sequences
// for IDLE exit, DWELL=1 scanning and reset mid-dwell.
module tb_chan_scan_mux;
    import chan_scan_pkg::*;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int SW = 2;
    localparam logic [N*W-1:0] DIN0 = 16'hDCBA;
    localparam logic [1:0] MM = 2'b00, MS = 2'b01, MH = 2'b10, MR = 2'b11;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] din;
    logic [SW-1:0]  sel;
    logic [1:0]     mode;
    logic [N-1:0]   en_mask;
    logic [W-1:0]   z, z1;
    logic [SW-1:0]  cur_ch, cur_ch1;
    logic           z_valid, z_valid1, wrap, wrap1;

    chan_scan_mux #(.W(W), .N(N), .DWELL(3)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .mode(mode), .en_mask(en_mask),
        .z(z), .cur_ch(cur_ch), .z_valid(z_valid), .wrap(wrap)
    );

    chan_scan_mux #(.W(W), .N(N), .DWELL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .mode(mode), .en_mask(en_mask),
        .z(z1), .cur_ch(cur_ch1), .z_valid(z_valid1), .wrap(wrap1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           rst_n;
        logic [1:0]     mode;
        logic [SW-1:0]  sel;
        logic [N-1:0]   en_mask;
        logic [N*W-1:0] din;
        logic [W-1:0]   z;
        logic [SW-1:0]  cur;
        logic           valid;
        logic           wrap;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic add(input logic r, input logic [1:0] m, input logic [SW-1:0] s,
                       input logic [N-1:0] msk, input logic [N*W-1:0] d,
                       input logic [W-1:0] ez, input logic [SW-1:0] ec,
                       input logic ev, input logic ew);
        vec_t v;
        v.rst_n = r; v.mode = m; v.sel = s; v.en_mask = msk; v.din = d;
        v.z = ez; v.cur = ec; v.valid = ev; v.wrap = ew;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; mode = MM; sel = '0; en_mask = '0; din = DIN0;
        step();
        step();

        // rst mode sel mask din | z cur valid wrap (outputs after the edge)
        add(0, MM, 0, 4'b0000, DIN0,     4'h0, 0, 0, 0);
        add(1, MM, 2, 4'b0000, DIN0,     4'h0, 0, 0, 0);  // IDLE exit cycle
        add(1, MM, 2, 4'b0000, DIN0,     4'hC, 2, 1, 0);
        add(1, MM, 0, 4'b0000, DIN0,     4'hA, 0, 1, 0);
        add(1, MM, 3, 4'b0000, 16'h1234, 4'h1, 3, 1, 0);
        add(1, MM, 1, 4'b0000, DIN0,     4'hB, 1, 1, 0);
        add(1, MM, 0, 4'b1011, DIN0,     4'hA, 0, 1, 0);
        add(1, MS, 0, 4'b1011, DIN0,     4'hA, 0, 1, 0);  // scan entry at ch0
        add(1, MS, 0, 4'b1011, DIN0,     4'hA, 0, 1, 0);
        add(1, MS, 0, 4'b1011, DIN0,     4'hA, 0, 1, 0);
        add(1, MS, 0, 4'b1011, DIN0,     4'hB, 1, 1, 0);
        add(1, MS, 0, 4'b1011, DIN0,     4'hB, 1, 1, 0);
        add(1, MS, 0, 4'b1011, DIN0,     4'hB, 1, 1, 0);
        add(1, MS, 0, 4'b1011, DIN0,     4'hD, 3, 1, 0);
        add(1, MS, 0, 4'b1011, DIN0,     4'hD, 3, 1, 0);
        add(1, MS, 0, 4'b1011, DIN0,     4'hD, 3, 1, 0);
        add(1, MS, 0, 4'b1011, DIN0,     4'hA, 0, 1, 1);  // 3 -> 0 wrap
        add(1, MS, 0, 4'b1011, 16'hDCB5, 4'h5, 0, 1, 0);  // live data in dwell
        add(1, MS, 0, 4'b1011, DIN0,     4'hA, 0, 1, 0);
        add(1, MS, 0, 4'b1011, DIN0,     4'hB, 1, 1, 0);
        add(1, MS, 0, 4'b1011, DIN0,     4'hB, 1, 1, 0);  // ch1 at count 1
        add(1, MS, 0, 4'b1001, DIN0,     4'hD, 3, 1, 0);  // ch1 disabled
        add(1, MS, 0, 4'b1001, DIN0,     4'hD, 3, 1, 0);
        add(1, MS, 0, 4'b1001, DIN0,     4'hD, 3, 1, 0);
        add(1, MS, 0, 4'b1001, DIN0,     4'hA, 0, 1, 1);
        add(1, MS, 0, 4'b1001, DIN0,     4'hA, 0, 1, 0);
        for (int i = 0; i < 5; i++)
            add(1, MH, 0, 4'b1001, {4{4'(i + 5)}}, 4'hA, 0, 1, 0);
        add(1, MS, 0, 4'b1001, DIN0,     4'hA, 0, 1, 0);  // resume, full dwell
        add(1, MS, 0, 4'b1001, DIN0,     4'hA, 0, 1, 0);
        add(1, MS, 0, 4'b1001, DIN0,     4'hA, 0, 1, 0);
        add(1, MS, 0, 4'b1001, DIN0,     4'hD, 3, 1, 0);
        add(1, MR, 0, 4'b1001, 16'h1111, 4'hD, 3, 1, 0);  // reserved = hold
        add(1, MR, 0, 4'b1001, DIN0,     4'hD, 3, 1, 0);
        add(1, MS, 0, 4'b0100, DIN0,     4'hC, 2, 1, 0);  // entry skips disabled ch3
        add(1, MS, 0, 4'b0100, DIN0,     4'hC, 2, 1, 0);
        add(1, MS, 0, 4'b0100, DIN0,     4'hC, 2, 1, 0);
        add(1, MS, 0, 4'b0100, DIN0,     4'hC, 2, 1, 1);  // single channel 2 -> 2
        add(1, MS, 0, 4'b0100, DIN0,     4'hC, 2, 1, 0);
        add(1, MS, 0, 4'b0000, DIN0,     4'h0, 2, 0, 0);  // empty mask
        add(1, MS, 0, 4'b0000, DIN0,     4'h0, 2, 0, 0);
        add(1, MS, 0, 4'b0100, DIN0,     4'hC, 2, 1, 0);
        add(0, MS, 0, 4'b0100, DIN0,     4'h0, 0, 0, 0);

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n; mode = vecs[i].mode; sel = vecs[i].sel;
            en_mask = vecs[i].en_mask; din = vecs[i].din;
            step();
            check($sformatf("row%0d z", i),     32'(z),       32'(vecs[i].z));
            check($sformatf("row%0d cur", i),   32'(cur_ch),  32'(vecs[i].cur));
            check($sformatf("row%0d valid", i), 32'(z_valid), 32'(vecs[i].valid));
            check($sformatf("row%0d wrap", i),  32'(wrap),    32'(vecs[i].wrap));
        end

        // Straight from reset into SCAN; dut1 has DWELL=1 and advances every edge.
        rst_n = 1'b1; mode = MS; sel = '0; en_mask = 4'b1011; din = DIN0;
        step();
        check("idle_exit z",     32'(z),          32'h0);
        check("idle_exit valid", 32'(z_valid1),   32'h0);
        check("idle_exit state", 32'(dut.state),  32'(ST_SCAN));
        step();
        check("d1 entry cur",    32'(cur_ch1),    32'h0);
        check("d1 entry z",      32'(z1),         32'hA);
        check("d3 entry cur",    32'(cur_ch),     32'h0);
        step();
        check("d1 adv1 cur",     32'(cur_ch1),    32'h1);
        check("d1 adv1 wrap",    32'(wrap1),      32'h0);
        step();
        check("d1 adv2 cur",     32'(cur_ch1),    32'h3);
        step();
        check("d1 adv3 cur",     32'(cur_ch1),    32'h0);
        check("d1 adv3 wrap",    32'(wrap1),      32'h1);
        check("d3 adv cur",      32'(cur_ch),     32'h1);
        step();
        check("d1 adv4 wrap",    32'(wrap1),      32'h0);
        check("d3 mid z",        32'(z),          32'hB);
        rst_n = 1'b0;
        step();
        check("rst_mid z",       32'(z),          32'h0);
        check("rst_mid cur",     32'(cur_ch),     32'h0);
        check("rst_mid valid",   32'(z_valid),    32'h0);
        check("rst_mid wrap",    32'(wrap),       32'h0);
        check("rst_mid state",   32'(dut.state),  32'(ST_IDLE));
        check("rst_mid d1 cur",  32'(cur_ch1),    32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
